// File: rtl/stream_xbar_router.sv
// N_INPUTS x N_OUTPUTS val/rdy stream crossbar with a FIFO on every output and
// runtime routing (one source per output, multicast allowed) written over a control channel.
module stream_xbar_router #(
   parameter int unsigned BIT_WIDTH = 32,
   parameter int unsigned N_INPUTS  = 2,
   parameter int unsigned N_OUTPUTS = 2,
   parameter int unsigned DEPTH     = 4,
   localparam int unsigned IN_W     = (N_INPUTS  > 1) ? $clog2(N_INPUTS)  : 1,
   localparam int unsigned OUT_W    = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1,
   localparam int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [N_INPUTS*BIT_WIDTH-1:0]   recv_msg,
   input  logic [N_INPUTS-1:0]             recv_val,
   output logic [N_INPUTS-1:0]             recv_rdy,
   output logic [N_OUTPUTS*BIT_WIDTH-1:0]  send_msg,
   output logic [N_OUTPUTS-1:0]            send_val,
   input  logic [N_OUTPUTS-1:0]            send_rdy,
   input  logic [OUT_W+IN_W:0]             control,
   input  logic                            control_val,
   output logic                            control_rdy,
   output logic [N_OUTPUTS*(1+IN_W)-1:0]   cfg_o,
   output logic [N_OUTPUTS*CNT_W-1:0]      occupancy
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic                   active_q;
   logic [N_OUTPUTS-1:0]   cfg_en;
   logic [IN_W-1:0]        cfg_src  [N_OUTPUTS];
   logic [BIT_WIDTH-1:0]   mem      [N_OUTPUTS][DEPTH];
   logic [PTR_W-1:0]       wr_ptr   [N_OUTPUTS];
   logic [PTR_W-1:0]       rd_ptr   [N_OUTPUTS];
   logic [CNT_W-1:0]       count    [N_OUTPUTS];

   logic [IN_W-1:0]        ctrl_in;
   logic [OUT_W-1:0]       ctrl_out;
   logic                   ctrl_en;
   logic                   ctrl_fire;
   logic                   ctrl_in_ok;

   logic [N_INPUTS-1:0]    sel_any;
   logic [N_INPUTS-1:0]    blocked;
   logic [N_OUTPUTS-1:0]   push;
   logic [N_OUTPUTS-1:0]   pop;
   logic [BIT_WIDTH-1:0]   push_data [N_OUTPUTS];

   assign ctrl_in     = control[IN_W-1:0];
   assign ctrl_out    = control[IN_W +: OUT_W];
   assign ctrl_en     = control[IN_W+OUT_W];
   assign control_rdy = active_q;
   assign ctrl_fire   = control_val && active_q;
   assign ctrl_in_ok  = 32'(ctrl_in) < N_INPUTS;

   // An input is ready only when it drives at least one output and none of its targets is full.
   always_comb begin
      sel_any = '0;
      blocked = '0;
      for (int unsigned i = 0; i < N_INPUTS; i++) begin
         for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
            if (cfg_en[j] && cfg_src[j] == IN_W'(i)) begin
               sel_any[i] = 1'b1;
               if (count[j] >= CNT_W'(DEPTH)) blocked[i] = 1'b1;
            end
         end
      end
      recv_rdy = active_q ? (sel_any & ~blocked) : '0;
   end

   always_comb begin
      push = '0;
      pop  = '0;
      for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
         push_data[j] = '0;
         for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (cfg_en[j] && cfg_src[j] == IN_W'(i) && recv_val[i] && recv_rdy[i]) begin
               push[j]      = 1'b1;
               push_data[j] = recv_msg[i*BIT_WIDTH +: BIT_WIDTH];
            end
         end
         pop[j] = (count[j] != '0) && send_rdy[j];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q <= 1'b0;
         for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
            cfg_en[j]  <= 1'b1;
            cfg_src[j] <= IN_W'(j % N_INPUTS);
            wr_ptr[j]  <= '0;
            rd_ptr[j]  <= '0;
            count[j]   <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) mem[j][k] <= '0;
         end
      end else begin
         active_q <= 1'b1;
         for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
            // Out-of-range out_sel matches no output, so the write is dropped.
            if (ctrl_fire && ctrl_out == OUT_W'(j)) begin
               cfg_en[j]  <= ctrl_en && ctrl_in_ok;
               cfg_src[j] <= ctrl_in;
            end
            if (push[j]) begin
               mem[j][wr_ptr[j]] <= push_data[j];
               wr_ptr[j]         <= wr_ptr[j] + 1'b1;
            end
            if (pop[j]) rd_ptr[j] <= rd_ptr[j] + 1'b1;
            case ({push[j], pop[j]})
               2'b10:   count[j] <= count[j] + 1'b1;
               2'b01:   count[j] <= count[j] - 1'b1;
               default: count[j] <= count[j];
            endcase
         end
      end
   end

   always_comb begin
      send_msg  = '0;
      send_val  = '0;
      cfg_o     = '0;
      occupancy = '0;
      for (int unsigned j = 0; j < N_OUTPUTS; j++) begin
         send_msg[j*BIT_WIDTH +: BIT_WIDTH] = mem[j][rd_ptr[j]];
         send_val[j]                        = count[j] != '0;
         cfg_o[j*(1+IN_W) +: 1+IN_W]        = {cfg_en[j], cfg_src[j]};
         occupancy[j*CNT_W +: CNT_W]        = count[j];
      end
   end

endmodule
